leitor_registradores: RTL
=========================

# leitor_registradores

Operand-fetch unit for the Nano MIPS datapath: holds a small bank of 8-bit registers written through a load-style write port and reads two operands (A, then B) back through a single shared read port under a start/valid handshake. It is the read-side counterpart to the bank's write path and feeds the ALU operand inputs. A compile-time option forwards a same-cycle write to the operand being read.

## Interface
- DATA_W, 8, width of each register and of the operand outputs
- N_REGS, 4, number of registers in the bank
- ADDR_W, 2, register address width (2^ADDR_W = N_REGS)

- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- we  input  1  write enable; write commits on the clk rising edge
- waddr  input  ADDR_W  write address
- dadoIn  input  DATA_W  write data
- start  input  1  request an operand fetch; sampled only in IDLE
- ra  input  ADDR_W  operand A address, latched with start
- rb  input  ADDR_W  operand B address, latched with start
- opA  output  DATA_W  operand A, registered
- opB  output  DATA_W  operand B, registered
- valid  output  1  one-cycle pulse: opA/opB complete and coherent
- busy  output  1  fetch in progress; start ignored while high

## Operation
- Reset (rst=0, any time, independent of clk): all bank registers, opA, opB = 0; valid = 0; busy = 0; state = IDLE. A fetch in progress is aborted; no valid is issued for it.
- Write port: when we=1, bank[waddr] <= dadoIn at the rising edge. Writes are accepted in every state, including during a fetch.
- FSM states: IDLE, LE_A, LE_B, FIM.
  - IDLE: start=1 -> latch ra, rb; go LE_A. Otherwise stay.
  - LE_A: read port address = latched ra; opA <= read value; go LE_B.
  - LE_B: read port address = latched rb; opB <= read value; go FIM.
  - FIM: valid = 1; go IDLE.
- busy = 1 in LE_A, LE_B, FIM; 0 in IDLE. valid = 1 only in FIM.
- start while busy is ignored (not queued). start held high: a new fetch begins on the first IDLE cycle after FIM.
- ra == rb is legal: both operands read the same register, each at its own read cycle.
- opA/opB hold their last captured value until overwritten by a later fetch; they are not cleared at IDLE.
- Write vs. read of the same register in the same cycle (we=1, waddr == current read address in LE_A/LE_B): result depends on Configuration. Write to a register not currently being read has no effect on the capture.
- Write and start in the same IDLE cycle: write commits; the subsequent reads see the new value.

## Timing
- start sampled at edge T0 (in IDLE) -> opA updates at T1, opB at T2, valid high during cycle after T2 (T2..T3), back in IDLE at T3.
- Fetch latency: valid asserted 3 cycles after the start edge; minimum start-to-start spacing 4 cycles.
- Outputs all registered; no combinational path from inputs to opA/opB/valid/busy.

## Configuration
- LEITOR_BYPASS_EN defined: in LE_A/LE_B, if we=1 and waddr equals the address being read, the captured operand is dadoIn (new value); bank is also written.
- LEITOR_BYPASS_EN undefined: captured operand is the bank's value before the edge (old value); new value appears only on a later fetch.

## Test plan
- Reset: drive rst=0 mid-LE_B after start -> opA=opB=0, valid=0, busy=0 immediately; after rst=1 no valid pulse appears.
- Basic fetch: write bank[1]=8'h3C, bank[2]=8'hA5; start ra=1, rb=2 -> opA=8'h3C at T1, opB=8'hA5 at T2, valid=1 exactly one cycle, busy high 3 cycles.
- Same address: bank[3]=8'h7F; start ra=3, rb=3 -> opA=opB=8'h7F.
- Collision: bank[0]=8'h11; start ra=0, rb=1; during LE_A drive we=1, waddr=0, dadoIn=8'h99 -> opA=8'h99 with LEITOR_BYPASS_EN, opA=8'h11 without; bank[0]=8'h99 afterwards in both.
- Start while busy: pulse start in LE_A with ra=2 -> ignored; only one valid, operands from first request.
- Back-to-back: start held high -> valid pulses every 4 cycles; change bank contents between fetches and check each fetch returns current values.

Source files
------------

// File: rtl/leitor_registradores_if.sv
// Operand-fetch bus for leitor_registradores: write port, fetch request and operand results.
interface leitor_registradores_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] dadoIn;
  logic              start;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              valid;
  logic              busy;

  modport master (output we, waddr, dadoIn, start, ra, rb,
                  input  opA, opB, valid, busy);
  modport slave  (input  we, waddr, dadoIn, start, ra, rb,
                  output opA, opB, valid, busy);
endinterface

// File: rtl/leitor_registradores.sv
// Register bank with a shared read port fetching operand A then B under start/valid.
// Define LEITOR_BYPASS_EN to forward a same-cycle write to the operand being captured.
module leitor_registradores #(
  parameter int DATA_W = 8,
  parameter int N_REGS = 4,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  leitor_registradores_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LE_A, LE_B, FIM} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_bank [N_REGS];
  logic [ADDR_W-1:0] r_ra, r_rb;
  logic [DATA_W-1:0] r_opA, r_opB;
  logic              r_valid, r_busy;
  logic [ADDR_W-1:0] w_raddr;
  logic [DATA_W-1:0] w_rdata;

  always_comb begin
    w_raddr = (r_state == LE_A) ? r_ra : r_rb;
    w_rdata = r_bank[w_raddr];
`ifdef LEITOR_BYPASS_EN
    if (bus.we && (bus.waddr == w_raddr)) w_rdata = bus.dadoIn;
`endif
  end

  // Writes are accepted in every state, independent of the fetch FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REGS; i++) r_bank[i] <= '0;
    end else if (bus.we) begin
      r_bank[bus.waddr] <= bus.dadoIn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_ra    <= bus.ra;
          r_rb    <= bus.rb;
          r_busy  <= 1'b1;
          r_state <= LE_A;
        end
        LE_A: begin
          r_opA   <= w_rdata;
          r_state <= LE_B;
        end
        LE_B: begin
          r_opB   <= w_rdata;
          r_valid <= 1'b1;
          r_state <= FIM;
        end
        FIM: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.opA   = r_opA;
  assign bus.opB   = r_opB;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
endmodule
